// File: rtl/intt_core.sv
// Inverse NTT over Z_Q. Loads N coefficients, transforms them in place with a single
// Gentleman-Sande butterfly, then streams the bit-reversed result scaled by N^-1.
module intt_core #(
   parameter int N          = 256,
   parameter int Q          = 12289,
   parameter int LOG_N      = 8,
   parameter int DATA_WIDTH = 14,
   parameter int N_INV      = 12241
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [LOG_N-2:0]      tw_addr,
   input  logic [DATA_WIDTH-1:0] tw_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done
);
   localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
   localparam int HW = LOG_N - 1;
   localparam int PW = 2 * DATA_WIDTH;
   localparam int TW = PW + DATA_WIDTH + 1;
   localparam logic [DATA_WIDTH-1:0] NINV      = DATA_WIDTH'(N_INV);
   localparam logic [DATA_WIDTH:0]   BAR_M     = (DATA_WIDTH+1)'((64'd1 << PW) / 64'(Q));
   localparam logic [LOG_N-1:0]      IDX_LAST  = LOG_N'(N - 1);
   localparam logic [HW-1:0]         BF_LAST   = {HW{1'b1}};
   localparam logic [SW-1:0]         STG_LAST  = SW'(LOG_N - 1);

   function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (DATA_WIDTH+1)'(Q)) s = s - (DATA_WIDTH+1)'(Q);
      return s[DATA_WIDTH-1:0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] mod_sub(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (a < b) d = d + (DATA_WIDTH+1)'(Q);
      return d[DATA_WIDTH-1:0];
   endfunction

   // Barrett reduction with k = 2*DATA_WIDTH: the quotient estimate is short by at most
   // one, so a single conditional subtract gives a fully reduced result.
   function automatic logic [DATA_WIDTH-1:0] mod_mul(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [PW-1:0] p;
      logic [TW-1:0] t;
      logic [PW-1:0] r;
      p = PW'(a) * PW'(b);
      t = TW'(p) * TW'(BAR_M);
      r = p - PW'(t[TW-1:PW]) * PW'(Q);
      if (r >= PW'(Q)) r = r - PW'(Q);
      return r[DATA_WIDTH-1:0];
   endfunction

   typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;
   state_t state_reg, state_next;

   logic                  in_ready_reg, out_valid_reg, done_reg;
   logic [DATA_WIDTH-1:0] out_data_reg;
   logic [LOG_N-1:0]      load_cnt_reg, fetch_cnt_reg, out_cnt_reg;
   logic [SW-1:0]         stage_reg;
   logic [HW-1:0]         bf_reg;
   logic                  phase_reg, fetch_done_reg, pipe_valid_reg;

   logic                  in_fire, load_last, comp_last, out_fire, out_last;
   logic                  adv_out, pipe_take, fetch_go;
   logic [HW-1:0]         mask, tw_idx;
   logic [LOG_N-1:0]      j_lo, j_hi, h_bit, fetch_rev;
   logic [DATA_WIDTH-1:0] in_reduced, bf_sum, bf_prod;

   logic [DATA_WIDTH-1:0] mem [N];
   logic [LOG_N-1:0]      addr_a, addr_b;
   logic                  we_a, we_b, re;
   logic [DATA_WIDTH-1:0] wd_a, wd_b, rd_a, rd_b;

   assign in_fire   = in_valid & in_ready_reg & (state_reg == ST_LOAD);
   assign load_last = in_fire & (load_cnt_reg == IDX_LAST);
   assign comp_last = (state_reg == ST_COMPUTE) & phase_reg & (bf_reg == BF_LAST) &
                      (stage_reg == STG_LAST);
   assign out_fire  = (state_reg == ST_UNLOAD) & out_valid_reg & out_ready;
   assign out_last  = out_fire & (out_cnt_reg == IDX_LAST);

   // Butterfly index b becomes j by inserting a zero at bit log2(h); j+h sets that bit.
   assign mask   = {HW{1'b1}} >> stage_reg;
   assign j_lo   = {bf_reg & ~mask, 1'b0} | {1'b0, bf_reg & mask};
   assign h_bit  = {1'b0, mask} + LOG_N'(1);
   assign j_hi   = j_lo | h_bit;
   assign tw_idx = (bf_reg & mask) << stage_reg;

   generate
      for (genvar gi = 0; gi < LOG_N; gi++) begin : g_rev
         assign fetch_rev[gi] = fetch_cnt_reg[LOG_N-1-gi];
      end
   endgenerate

   assign in_reduced = (in_data >= DATA_WIDTH'(Q)) ? in_data - DATA_WIDTH'(Q) : in_data;
   assign bf_sum     = mod_add(rd_a, rd_b);
   assign bf_prod    = mod_mul(mod_sub(rd_a, rd_b), tw_data);

   // Unload pipeline: RAM read register feeds the scaled output register; both hold on stall.
   assign adv_out   = ~out_valid_reg | out_ready;
   assign pipe_take = (state_reg == ST_UNLOAD) & pipe_valid_reg & adv_out;
   assign fetch_go  = (state_reg == ST_UNLOAD) & ~fetch_done_reg & (~pipe_valid_reg | adv_out);

   always_comb begin
      addr_a = load_cnt_reg;
      addr_b = j_hi;
      we_a   = 1'b0;
      we_b   = 1'b0;
      re     = 1'b0;
      wd_a   = in_reduced;
      wd_b   = bf_prod;
      case (state_reg)
         ST_LOAD: we_a = in_fire;
         ST_COMPUTE: begin
            addr_a = j_lo;
            re     = ~phase_reg;
            we_a   = phase_reg;
            we_b   = phase_reg;
            wd_a   = bf_sum;
         end
         ST_UNLOAD: begin
            addr_a = fetch_rev;
            re     = fetch_go;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wd_a;
      if (we_b) mem[addr_b] <= wd_b;
      if (re) begin
         rd_a <= mem[addr_a];
         rd_b <= mem[addr_b];
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_LOAD:    if (load_last) state_next = ST_COMPUTE;
         ST_COMPUTE: if (comp_last) state_next = ST_UNLOAD;
         ST_UNLOAD:  if (out_last)  state_next = ST_LOAD;
         default:    state_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_LOAD;
         in_ready_reg   <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         done_reg       <= 1'b0;
         load_cnt_reg   <= '0;
         stage_reg      <= '0;
         bf_reg         <= '0;
         phase_reg      <= 1'b0;
         fetch_cnt_reg  <= '0;
         fetch_done_reg <= 1'b0;
         pipe_valid_reg <= 1'b0;
         out_cnt_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= (state_next == ST_LOAD);
         done_reg     <= out_last;

         if (in_fire)
            load_cnt_reg <= (load_cnt_reg == IDX_LAST) ? '0 : load_cnt_reg + LOG_N'(1);

         if (state_reg == ST_COMPUTE) begin
            phase_reg <= ~phase_reg;
            if (phase_reg) begin
               if (bf_reg == BF_LAST) begin
                  bf_reg    <= '0;
                  stage_reg <= (stage_reg == STG_LAST) ? '0 : stage_reg + SW'(1);
               end else begin
                  bf_reg <= bf_reg + HW'(1);
               end
            end
            fetch_cnt_reg  <= '0;
            fetch_done_reg <= 1'b0;
            pipe_valid_reg <= 1'b0;
            out_cnt_reg    <= '0;
            out_valid_reg  <= 1'b0;
         end

         if (state_reg == ST_UNLOAD) begin
            if (fetch_go) begin
               fetch_cnt_reg <= (fetch_cnt_reg == IDX_LAST) ? '0 : fetch_cnt_reg + LOG_N'(1);
               if (fetch_cnt_reg == IDX_LAST) fetch_done_reg <= 1'b1;
            end
            if (fetch_go)       pipe_valid_reg <= 1'b1;
            else if (pipe_take) pipe_valid_reg <= 1'b0;

            if (out_fire)
               out_cnt_reg <= (out_cnt_reg == IDX_LAST) ? '0 : out_cnt_reg + LOG_N'(1);

            if (out_last) begin
               out_valid_reg <= 1'b0;
            end else if (pipe_take) begin
               out_valid_reg <= 1'b1;
               out_data_reg  <= mod_mul(rd_a, NINV);
            end else if (out_fire) begin
               out_valid_reg <= 1'b0;
            end
         end
      end
   end

   assign in_ready  = in_ready_reg;
   assign tw_addr   = (state_reg == ST_COMPUTE) ? tw_idx : '0;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign busy      = (state_reg != ST_LOAD);
   assign done      = done_reg;

endmodule

// File: tb/tb_intt_core.sv
// Scoreboard bench for intt_core: expected outputs come from a direct O(N^2) inverse DFT
// (or from the original polynomial in round-trip frames) and are checked by a monitor.
module tb_intt_core;
   localparam int N     = 256;
   localparam int Q     = 12289;
   localparam int LOG_N = 8;
   localparam int DW    = 14;
   localparam int N_INV = 12241;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic [DW-1:0] tw_data = '0;
   logic          in_ready, out_valid, busy, done;
   logic [DW-1:0] out_data;
   logic [LOG_N-2:0] tw_addr;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int done_cnt = 0;
   int out_cnt  = 0;
   int bp_mode  = 0;
   bit hold_pending = 0;
   logic [DW-1:0] hold_data;
   int rom[N/2];
   int w_pow[N];
   int winv_pow[N];
   int frame_in[N];
   int frame_exp[N];

   intt_core #(.N(N), .Q(Q), .LOG_N(LOG_N), .DATA_WIDTH(DW), .N_INV(N_INV)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .tw_addr(tw_addr), .tw_data(tw_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tw_data <= DW'(rom[tw_addr]);

   function automatic int modpow(input int b, input int e);
      longint r, x;
      r = 1;
      x = longint'(b % Q);
      while (e > 0) begin
         if ((e & 1) != 0) r = (r * x) % Q;
         x = (x * x) % Q;
         e = e >> 1;
      end
      return int'(r);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // x[j] = N^-1 * sum_k X[k] * omega^(-jk)
   task automatic ref_intt();
      longint acc;
      for (int j = 0; j < N; j++) begin
         acc = 0;
         for (int k = 0; k < N; k++)
            acc = (acc + longint'(frame_in[k] % Q) * winv_pow[(j * k) % N]) % Q;
         frame_exp[j] = int'((acc * N_INV) % Q);
      end
   endtask

   initial forever begin
      int ph;
      @(posedge clk);
      #1;
      ph = $urandom_range(0, 3);
      case (bp_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (ph == 0) || (ph == 3);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      if (reset) begin
         hold_pending = 0;
      end else begin
         if (done) done_cnt++;
         if (hold_pending) begin
            n_checks++;
            if (!out_valid || out_data !== hold_data) begin
               n_fail++;
               $display("FAIL hold: valid=%0b data=%0d, expected valid=1 data=%0d",
                        out_valid, out_data, hold_data);
            end
            hold_pending = 0;
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_out: got %0d, expected no output", out_data);
            end else begin
               int e;
               e = exp_q.pop_front();
               if (int'(out_data) !== e) begin
                  n_fail++;
                  $display("FAIL out[%0d]: got %0d, expected %0d", out_cnt, out_data, e);
               end
            end
            out_cnt++;
         end else if (out_valid) begin
            hold_pending = 1;
            hold_data = out_data;
         end
      end
   end

   task automatic send_frame();
      int  k, guard;
      bit  fire;
      k = 0;
      guard = 0;
      while (k < N && guard < 4000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = DW'(frame_in[k]);
         @(negedge clk);
         fire = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (fire) k++;
         guard++;
      end
      in_valid = 1'b0;
      if (k < N) chk("load_timeout", k, N);
   endtask

   task automatic run_frame(input string name, input bit junk, input bit measure);
      int cyc, cnt;
      done_cnt = 0;
      out_cnt  = 0;
      for (int j = 0; j < N; j++) exp_q.push_back(frame_exp[j]);
      send_frame();
      if (measure) begin
         chk("busy_after_load", int'(busy), 1);
         chk("in_ready_after_load", int'(in_ready), 0);
         cnt = 0;
         cyc = 0;
         while (!out_valid && cyc < 6000) begin
            @(negedge clk);
            if (busy && !out_valid) cnt++;
            cyc++;
         end
         n_checks++;
         if (cnt < 2048 || cnt > 2052) begin
            n_fail++;
            $display("FAIL compute_cycles: got %0d, expected 2048 plus at most 4 unload latency", cnt);
         end
         @(posedge clk);
         #1;
      end
      cyc = 0;
      while (done_cnt == 0 && cyc < 8000) begin
         if (junk && out_cnt == 0) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk({name, "_outputs"}, out_cnt, N);
      chk({name, "_done_pulses"}, done_cnt, 1);
      chk({name, "_queue_left"}, exp_q.size(), 0);
      chk({name, "_busy_idle"}, int'(busy), 0);
      $display("frame %-10s outputs=%0d done_pulses=%0d cycles_waited=%0d", name, out_cnt, done_cnt, cyc);
      exp_q.delete();
   endtask

   task automatic random_frame();
      for (int k = 0; k < N; k++) frame_in[k] = int'($urandom_range(0, (1 << DW) - 1));
      ref_intt();
   endtask

   task automatic roundtrip_frame();
      longint acc;
      for (int j = 0; j < N; j++) frame_exp[j] = int'($urandom_range(0, Q - 1));
      for (int k = 0; k < N; k++) begin
         acc = 0;
         for (int j = 0; j < N; j++)
            acc = (acc + longint'(frame_exp[j]) * w_pow[(j * k) % N]) % Q;
         frame_in[k] = int'(acc);
      end
   endtask

   initial begin
      int w, winv, g;
      w = 0;
      g = 2;
      while (w == 0) begin
         int c;
         c = modpow(g, (Q - 1) / N);
         if (modpow(c, N / 2) != 1) w = c;
         g++;
      end
      winv = modpow(w, Q - 2);
      for (int i = 0; i < N; i++) begin
         w_pow[i]    = modpow(w, i);
         winv_pow[i] = modpow(winv, i);
      end
      for (int i = 0; i < N / 2; i++) rom[i] = winv_pow[i];

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_tw_addr", int'(tw_addr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("in_ready_before_clk", int'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("in_ready_after_clk", int'(in_ready), 1);

      for (int k = 0; k < N; k++) begin frame_in[k] = 0; frame_exp[k] = 0; end
      run_frame("zeros", 1'b0, 1'b1);

      for (int k = 0; k < N; k++) begin frame_in[k] = (k == 0) ? 256 : 0; frame_exp[k] = 1; end
      run_frame("dc", 1'b0, 1'b0);

      for (int k = 0; k < N; k++) begin frame_in[k] = 1; frame_exp[k] = (k == 0) ? 1 : 0; end
      run_frame("delta", 1'b1, 1'b0);

      for (int k = 0; k < N; k++) begin
         frame_in[k]  = (k == 0) ? Q + 5 : 0;
         frame_exp[k] = (5 * N_INV) % Q;
      end
      run_frame("range", 1'b0, 1'b0);

      bp_mode = 1;
      random_frame();
      run_frame("bp_pattern", 1'b0, 1'b0);
      bp_mode = 2;
      random_frame();
      run_frame("bp_random", 1'b0, 1'b0);

      roundtrip_frame();
      run_frame("roundtrip", 1'b0, 1'b0);

      bp_mode = 0;
      done_cnt = 0;
      out_cnt  = 0;
      random_frame();
      send_frame();
      repeat (300) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("abort_in_ready", int'(in_ready), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_tw_addr", int'(tw_addr), 0);
      chk("abort_out_data", int'(out_data), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_in_ready_rise", int'(in_ready), 1);
      chk("abort_no_outputs", out_cnt, 0);
      $display("frame %-10s aborted by reset during compute", "abort");

      bp_mode = 2;
      roundtrip_frame();
      run_frame("post_abort", 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
